// File: rtl/ntt_sequencer.sv
// Address / twiddle / control sequencer for an in-place 256-point NTT (CT forward, GS inverse).
// Issues one butterfly per cycle and replays the operand addresses as write-backs PIPE cycles later.
module ntt_sequencer #(
    parameter int PIPE = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       inverse_i,
    input  logic       sel_red_i,
    output logic       rd_en_o,
    output logic [7:0] rd_addr_a_o,
    output logic [7:0] rd_addr_b_o,
    output logic [7:0] zeta_idx_o,
    output logic       sel_butterfly_o,
    output logic       sel_red_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_a_o,
    output logic [7:0] wr_addr_b_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CW = (PIPE > 1) ? $clog2(PIPE) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      s_q, s_d;
    logic [6:0]      c_q, c_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            inv_q, inv_d, red_q, red_d;
    logic            last_stage, cnt_end, issue;

    assign last_stage = red_q ? (s_q == 3'd6) : (s_q == 3'd7);
    assign cnt_end    = (cnt_q == CW'(PIPE - 1));
    assign issue      = (state_q == ISSUE);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        red_d   = red_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = ISSUE;
                inv_d   = inverse_i;
                red_d   = sel_red_i;
                s_d     = 3'd0;
                c_d     = 7'd0;
                cnt_d   = '0;
            end
            ISSUE: begin
                c_d   = c_q + 7'd1;
                cnt_d = '0;
                if (c_q == 7'd127) state_d = last_stage ? DRAIN : GAP;
            end
            // GAP lets the last write of a stage land before the next stage reads it
            GAP: if (cnt_end) begin
                state_d = ISSUE;
                s_d     = s_q + 3'd1;
                c_d     = 7'd0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            DRAIN: if (cnt_end) state_d = DONE;
                   else         cnt_d   = cnt_q + CW'(1);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            s_q     <= 3'd0;
            c_q     <= 7'd0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            red_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            red_q   <= red_d;
        end
    end

    // lg = log2(half-span); group g = c>>lg, a = g*2*len + (c mod len)
    logic [2:0] lg;
    logic [3:0] lg1;
    logic [7:0] len, g, a, b;
    logic [8:0] zeta;

    always_comb begin
        lg   = inv_q ? (s_q + {2'b00, red_q}) : (3'd7 - s_q);
        lg1  = {1'b0, lg} + 4'd1;
        len  = 8'd1 << lg;
        g    = {1'b0, c_q} >> lg;
        a    = (g << lg1) | ({1'b0, c_q} & (len - 8'd1));
        b    = a + len;
        zeta = inv_q ? ((9'd256 >> lg) - 9'd1 - {1'b0, g})
                     : ((9'd128 >> lg) + {1'b0, g});
    end

    assign rd_en_o     = issue;
    assign rd_addr_a_o = issue ? a : 8'd0;
    assign rd_addr_b_o = issue ? b : 8'd0;
    assign zeta_idx_o  = issue ? zeta[7:0] : 8'd0;

    logic [PIPE-1:0]       wen_q;
    logic [PIPE-1:0][7:0]  wa_q, wb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wen_q <= '0;
            wa_q  <= '0;
            wb_q  <= '0;
        end else begin
            wen_q[0] <= rd_en_o;
            wa_q[0]  <= rd_addr_a_o;
            wb_q[0]  <= rd_addr_b_o;
            for (int i = 1; i < PIPE; i++) begin
                wen_q[i] <= wen_q[i-1];
                wa_q[i]  <= wa_q[i-1];
                wb_q[i]  <= wb_q[i-1];
            end
        end
    end

    assign wr_en_o         = wen_q[PIPE-1];
    assign wr_addr_a_o     = wa_q[PIPE-1];
    assign wr_addr_b_o     = wb_q[PIPE-1];
    assign sel_butterfly_o = inv_q;
    assign sel_red_o       = red_q;
    assign busy_o          = (state_q == ISSUE) || (state_q == GAP) || (state_q == DRAIN);
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_ntt_sequencer.sv
// Bench for ntt_sequencer: per-cycle comparison against a loop-nest NTT schedule model,
// plus write-tracking, protocol-robustness and asynchronous-reset scenarios.
module tb_ntt_sequencer;
    localparam int PIPE = 2;
    localparam int NC   = 1200;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, inv = 1'b0, red = 1'b0;
    logic       rd_en, bf, sr, wr_en, busy, done;
    logic [7:0] ra, rb, z, wa, wb;

    ntt_sequencer #(.PIPE(PIPE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .inverse_i(inv), .sel_red_i(red),
        .rd_en_o(rd_en), .rd_addr_a_o(ra), .rd_addr_b_o(rb), .zeta_idx_o(z),
        .sel_butterfly_o(bf), .sel_red_o(sr), .wr_en_o(wr_en),
        .wr_addr_a_o(wa), .wr_addr_b_o(wb), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference schedule: textbook loop nest over stages, groups and butterflies
    logic       e_rd [NC];
    logic [7:0] e_a [NC], e_b [NC], e_z [NC];
    int         e_stg [NC];
    int         e_done, e_S;

    logic       o_rd [NC], o_done [NC];
    logic [7:0] o_a [NC], o_b [NC], o_z [NC];
    int         wcount [256];

    task automatic build(input bit i, input bit r);
        int cyc;
        for (int c = 0; c < NC; c++) begin
            e_rd[c] = 1'b0; e_a[c] = 8'd0; e_b[c] = 8'd0; e_z[c] = 8'd0; e_stg[c] = -1;
        end
        e_S = r ? 7 : 8;
        cyc = 1;
        for (int s = 0; s < e_S; s++) begin
            int len, k;
            len = i ? ((r ? 2 : 1) << s) : (128 >> s);
            k   = i ? (256 / len - 1) : (128 / len);
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = 0; j < len; j++) begin
                    e_rd[cyc] = 1'b1; e_a[cyc] = 8'(st + j); e_b[cyc] = 8'(st + j + len);
                    e_z[cyc] = 8'(k); e_stg[cyc] = s;
                    cyc++;
                end
                k = i ? k - 1 : k + 1;
            end
            cyc += PIPE;
        end
        e_done = cyc;
    endtask

    function automatic logic [63:0] pack();
        return {18'd0, rd_en, ra, rb, z, bf, sr, wr_en, wa, wb, busy, done};
    endfunction

    function automatic logic [63:0] expv(input int cyc, input bit i, input bit r);
        logic       w;
        logic [7:0] xa, xb;
        w  = (cyc >= PIPE) ? e_rd[cyc-PIPE] : 1'b0;
        xa = (cyc >= PIPE) ? e_a[cyc-PIPE] : 8'd0;
        xb = (cyc >= PIPE) ? e_b[cyc-PIPE] : 8'd0;
        return {18'd0, e_rd[cyc], e_a[cyc], e_b[cyc], e_z[cyc], i, r, w, xa, xb,
                (cyc >= 1 && cyc < e_done), (cyc == e_done)};
    endfunction

    // Caller leaves start=1 with mode bits set at a negedge (cycle 0).
    task automatic run(input bit i, input bit r, input bit perturb, input int rst_at,
                       input bit start_at_done);
        int rdn, hazard, badw;
        build(i, r);
        rdn = 0; hazard = 0; badw = 0;
        for (int k = 0; k < 256; k++) wcount[k] = 0;
        for (int cyc = 1; cyc <= e_done + 1; cyc++) begin
            @(negedge clk);
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_midrun", pack(), 64'd0);
                start = 1'b0;
                repeat (2) @(negedge clk);
                chk("reset_hold", pack(), 64'd0);
                rst_n = 1'b1;
                return;
            end
            chk($sformatf("cyc%0d", cyc), pack(), expv(cyc, i, r));
            o_rd[cyc] = rd_en; o_a[cyc] = ra; o_b[cyc] = rb; o_z[cyc] = z; o_done[cyc] = done;
            if (rd_en) begin
                rdn++;
                if (wcount[ra] != e_stg[cyc] || wcount[rb] != e_stg[cyc]) hazard++;
            end
            if (wr_en) begin
                wcount[wa]++;
                wcount[wb]++;
            end
            if (perturb && cyc < e_done - 1) begin
                start = 1'($urandom); inv = 1'($urandom); red = 1'($urandom);
            end else begin
                inv = i; red = r;
                if (start_at_done && cyc >= e_done - 1) start = 1'b1;
                else start = 1'b0;
            end
        end
        for (int k = 0; k < 256; k++) if (wcount[k] != e_S) badw++;
        chk("rd_count", 64'(rdn), 64'(128 * e_S));
        chk("raw_hazard", 64'(hazard), 64'd0);
        chk("write_once_per_stage", 64'(badw), 64'd0);
    endtask

    initial begin
        // Reset with random inputs
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'($urandom); inv = 1'($urandom); red = 1'($urandom);
            #1 chk("in_reset", pack(), 64'd0);
        end
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_after_reset", pack(), 64'd0);
        end

        // Kyber forward
        inv = 1'b0; red = 1'b1; start = 1'b1;
        run(1'b0, 1'b1, 1'b0, 0, 1'b0);
        chk("kf_c1", {o_a[1], o_b[1], o_z[1]}, {8'd0, 8'd128, 8'd1});
        chk("kf_c2", {o_a[2], o_b[2], o_z[2]}, {8'd1, 8'd129, 8'd1});
        chk("kf_gap", {o_rd[129], o_rd[130]}, 2'b00);
        chk("kf_c131", {o_a[131], o_b[131], o_z[131]}, {8'd0, 8'd64, 8'd2});
        chk("kf_c195", {o_a[195], o_b[195], o_z[195]}, {8'd128, 8'd192, 8'd3});
        chk("kf_last_first", {o_a[781], o_b[781], o_z[781]}, {8'd0, 8'd2, 8'd64});
        chk("kf_last_end", {o_a[908], o_b[908], o_z[908]}, {8'd253, 8'd255, 8'd127});
        chk("kf_done911", 64'(o_done[911]), 64'd1);

        // Dilithium inverse, with start_i raised in the done cycle and held one more
        @(negedge clk);
        inv = 1'b1; red = 1'b0; start = 1'b1;
        run(1'b1, 1'b0, 1'b0, 0, 1'b1);
        chk("di_c1", {o_a[1], o_b[1], o_z[1]}, {8'd0, 8'd1, 8'd255});
        chk("di_c2", {o_a[2], o_b[2], o_z[2]}, {8'd2, 8'd3, 8'd254});
        chk("di_final", {o_a[911], o_b[911], o_z[911]}, {8'd0, 8'd128, 8'd1});
        chk("di_done1041", 64'(o_done[1041]), 64'd1);

        // Chained start accepted one cycle after done; mid-run input noise
        inv = 1'b0; red = 1'b0;
        run(1'b0, 1'b0, 1'b1, 0, 1'b0);

        // Kyber inverse reset in stage 3, then a clean full run
        @(negedge clk);
        inv = 1'b1; red = 1'b1; start = 1'b1;
        run(1'b1, 1'b1, 1'b0, 1 + 3 * (128 + PIPE) + 10, 1'b0);
        inv = 1'b1; red = 1'b1; start = 1'b1;
        run(1'b1, 1'b1, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
